// File: rtl/diy_uart_pkg.sv
// diy_uart_pkg: shared register indices, AXI response codes and FSM state types for diyUart
package diy_uart_pkg;
    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_BAUD      = 2'd1;
    localparam logic [1:0] REG_TXDATA    = 2'd2;
    localparam logic [1:0] REG_SCRATCH   = 2'd3;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/diy_uart_axil_regs.sv
// diy_uart_axil_regs: AXI4-Lite slave holding the CTRL, BAUD_DIV, TX_DATA and SCRATCH registers
module diy_uart_axil_regs
    import diy_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BAUD_RESET = 868
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [DATA_WIDTH-1:0]   ctrl_o,
    output logic [DATA_WIDTH-1:0]   baud_div_o,
    output logic [DATA_WIDTH-1:0]   tx_data_o,
    output logic                    tx_wr_o,
    output logic [DATA_WIDTH-1:0]   scratch_o
);
    wr_state_t               r_wst, w_wst_nxt;
    rd_state_t               r_rst, w_rst_nxt;
    logic                    r_live;
    logic [DATA_WIDTH-1:0]   r_regs [4];
    logic [1:0]              r_aw_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_tx_wr;
    logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [1:0]              w_idx;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_unused;

    // r_live keeps the ready signals low until the first cycle out of reset
    assign S_AXI_AWREADY = r_live && (r_wst == W_IDLE || r_wst == W_HAVE_W);
    assign S_AXI_WREADY  = r_live && (r_wst == W_IDLE || r_wst == W_HAVE_AW);
    assign S_AXI_ARREADY = r_live && r_rst == R_IDLE;
    assign S_AXI_BVALID  = r_wst == W_RESP;
    assign S_AXI_RVALID  = r_rst == R_DATA;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign S_AXI_RDATA   = r_rdata;
    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_idx   = r_wst == W_HAVE_AW ? r_aw_idx : S_AXI_AWADDR[3:2];
    assign w_data  = r_wst == W_HAVE_W ? r_wdata : S_AXI_WDATA;
    assign w_strb  = r_wst == W_HAVE_W ? r_wstrb : S_AXI_WSTRB;
    assign ctrl_o     = r_regs[REG_CTRL];
    assign baud_div_o = r_regs[REG_BAUD];
    assign tx_data_o  = r_regs[REG_TXDATA];
    assign scratch_o  = r_regs[REG_SCRATCH];
    assign tx_wr_o    = r_tx_wr;
    assign w_unused   = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wst <= W_IDLE;
            r_rst <= R_IDLE;
        end else begin
            r_wst <= w_wst_nxt;
            r_rst <= w_rst_nxt;
        end
    end

    always_comb begin
        w_wst_nxt = r_wst;
        w_commit  = 1'b0;
        case (r_wst)
            W_IDLE: begin
                w_commit  = w_aw_hs && w_w_hs;
                w_wst_nxt = w_commit ? W_RESP : w_aw_hs ? W_HAVE_AW : w_w_hs ? W_HAVE_W : W_IDLE;
            end
            W_HAVE_AW: begin
                w_commit  = w_w_hs;
                w_wst_nxt = w_w_hs ? W_RESP : W_HAVE_AW;
            end
            W_HAVE_W: begin
                w_commit  = w_aw_hs;
                w_wst_nxt = w_aw_hs ? W_RESP : W_HAVE_W;
            end
            default: w_wst_nxt = S_AXI_BREADY ? W_IDLE : W_RESP;
        endcase
    end

    always_comb begin
        w_rst_nxt = r_rst;
        if (r_rst == R_IDLE) w_rst_nxt = w_ar_hs ? R_DATA : R_IDLE;
        else w_rst_nxt = S_AXI_RREADY ? R_IDLE : R_DATA;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_live    <= 1'b0;
            r_tx_wr   <= 1'b0;
            r_rdata   <= '0;
            r_regs[0] <= '0;
            r_regs[1] <= DATA_WIDTH'(BAUD_RESET);
            r_regs[2] <= '0;
            r_regs[3] <= '0;
        end else begin
            r_live  <= 1'b1;
            r_tx_wr <= w_commit && w_idx == REG_TXDATA;
            if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[3:2];
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            // nonblocking capture returns the pre-write value on a same-cycle commit
            if (w_ar_hs) r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (w_commit && w_strb[b]) r_regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
    end
endmodule
